// File: rtl/flow_led_ctrl.sv
// Parametrised LED pattern generator: rotate left/right, bounce and fill/drain
// with a programmable prescaler, run-time speed divider and pause.
module flow_led_ctrl #(
  parameter int N_LED    = 8,
  parameter int TICK_MAX = 24999999
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             step_tick,
  output logic             dir
);

  localparam int CW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

  localparam logic [1:0] MODE_ROL  = 2'b00;
  localparam logic [1:0] MODE_ROR  = 2'b01;
  localparam logic [1:0] MODE_BNC  = 2'b10;
  localparam logic [1:0] MODE_FILL = 2'b11;

  localparam logic [CW-1:0]    TICK_LIM = CW'(TICK_MAX);
  localparam logic [N_LED-1:0] LED_LSB  = N_LED'(1);
  localparam logic [N_LED-1:0] LED_MSB  = {1'b1, {(N_LED-1){1'b0}}};

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    lim;
  logic [1:0]       cur_mode;
  logic [N_LED-1:0] led_nxt;
  logic [N_LED-1:0] start_led;
  logic             dir_nxt;
  logic             fire;

  assign lim  = TICK_LIM >> speed;
  // >= so that a speed increase mid-count still fires promptly
  assign fire = (cnt >= lim);

  always_comb begin
    case (mode)
      MODE_ROR:  start_led = LED_MSB;
      MODE_FILL: start_led = '0;
      default:   start_led = LED_LSB;
    endcase
  end

  always_comb begin
    led_nxt = led;
    dir_nxt = dir;
    case (cur_mode)
      MODE_ROL: begin
        led_nxt = {led[N_LED-2:0], led[N_LED-1]};
        dir_nxt = 1'b0;
      end
      MODE_ROR: begin
        led_nxt = {led[0], led[N_LED-1:1]};
        dir_nxt = 1'b1;
      end
      MODE_BNC: begin
        if (!dir) begin
          if (led[N_LED-1]) begin
            dir_nxt = 1'b1;
            led_nxt = led >> 1;
          end else begin
            led_nxt = led << 1;
          end
        end else begin
          if (led[0]) begin
            dir_nxt = 1'b0;
            led_nxt = led << 1;
          end else begin
            led_nxt = led >> 1;
          end
        end
      end
      default: begin
        if (!dir) begin
          if (&led) begin
            dir_nxt = 1'b1;
            led_nxt = led >> 1;
          end else begin
            led_nxt = {led[N_LED-2:0], 1'b1};
          end
        end else begin
          if (led == '0) begin
            dir_nxt = 1'b0;
            led_nxt = LED_LSB;
          end else begin
            led_nxt = led >> 1;
          end
        end
      end
    endcase
  end

  // Restart on mode change outranks both pause and a pending tick
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led       <= LED_LSB;
      dir       <= 1'b0;
      step_tick <= 1'b0;
      cnt       <= '0;
      cur_mode  <= MODE_ROL;
    end else if (mode != cur_mode) begin
      cur_mode  <= mode;
      cnt       <= '0;
      dir       <= 1'b0;
      led       <= start_led;
      step_tick <= 1'b0;
    end else if (pause) begin
      step_tick <= 1'b0;
    end else if (fire) begin
      cnt       <= '0;
      led       <= led_nxt;
      dir       <= dir_nxt;
      step_tick <= 1'b1;
    end else begin
      cnt       <= cnt + CW'(1);
      step_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Bench for flow_led_ctrl: directed scenarios plus random mode/speed/pause/reset
// traffic, checked each cycle against a step-index pattern model.
module tb_flow_led_ctrl;

  localparam int N  = 4;
  localparam int TM = 3;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic [1:0]   mode    = 2'b00;
  logic [1:0]   speed   = 2'b00;
  logic         pause   = 1'b0;
  logic [N-1:0] led;
  logic         step_tick;
  logic         dir;

  int n_cmp = 0;
  int n_err = 0;

  // model state: active mode, prescaler count, steps taken since (re)start
  int m_mode = 0;
  int m_cnt  = 0;
  int m_k    = 0;
  bit m_tick = 0;

  flow_led_ctrl #(.N_LED(N), .TICK_MAX(TM)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .mode     (mode),
    .speed    (speed),
    .pause    (pause),
    .led      (led),
    .step_tick(step_tick),
    .dir      (dir)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_led(input int md, input int k);
    int p;
    case (md)
      0: return 1 << (k % N);
      1: return 1 << (N - 1 - (k % N));
      2: begin
        p = k % (2*N - 2);
        return 1 << ((p < N) ? p : (2*N - 2 - p));
      end
      default: begin
        p = k % (2*N);
        return (p <= N) ? ((1 << p) - 1) : ((1 << (2*N - p)) - 1);
      end
    endcase
  endfunction

  function automatic int exp_dir(input int md, input int k);
    int p;
    case (md)
      0: return 0;
      1: return (k > 0) ? 1 : 0;
      2: begin
        p = k % (2*N - 2);
        return ((p >= N) || (p == 0 && k > 0)) ? 1 : 0;
      end
      default: begin
        p = k % (2*N);
        return ((p > N) || (p == 0 && k > 0)) ? 1 : 0;
      end
    endcase
  endfunction

  task automatic model_edge();
    int lim;
    lim = TM >> speed;
    if (sys_rst) begin
      m_mode = 0; m_cnt = 0; m_k = 0; m_tick = 0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_cnt = 0; m_k = 0; m_tick = 0;
    end else if (pause) begin
      m_tick = 0;
    end else if (m_cnt >= lim) begin
      m_cnt = 0; m_k++; m_tick = 1;
    end else begin
      m_cnt++; m_tick = 0;
    end
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic cycle(input string tag);
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check({tag, ".led"},  32'(led),       32'(exp_led(m_mode, m_k)));
    check({tag, ".dir"},  32'(dir),       32'(exp_dir(m_mode, m_k)));
    check({tag, ".tick"}, 32'(step_tick), 32'(m_tick));
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    // reset, then rotate left
    sys_rst = 1'b1;
    run("rst", 2);
    check("rst.led_const", 32'(led), 32'h1);
    sys_rst = 1'b0;
    run("rol", 18);

    // bounce through two full periods
    mode = 2'b10;
    run("bnc", 30);

    // fill/drain through more than one period
    mode = 2'b11;
    run("fill", 40);

    // rotate right, then jump to speed 3 at cnt = 2
    mode = 2'b01;
    run("ror", 15);
    speed = 2'b11;
    run("spd3", 8);
    speed = 2'b00;
    run("spd0", 6);

    // pause at cnt = 1 for 10 cycles, then release; then mode change while paused
    mode = 2'b00;
    run("rol2", 6);
    pause = 1'b1;
    run("pause", 10);
    pause = 1'b0;
    run("resume", 6);
    pause = 1'b1;
    mode  = 2'b10;
    run("pause_mode", 3);
    pause = 1'b0;
    run("bnc2", 20);

    // reset asserted during bounce while dir = 1, released with mode still bounce
    sys_rst = 1'b1;
    run("rst2", 1);
    check("rst2.dir_const", 32'(dir), 32'h0);
    sys_rst = 1'b0;
    run("bnc3", 12);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) mode  = 2'($urandom);
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom);
      if ($urandom_range(0, 9) == 0)  pause = ($urandom_range(0, 3) == 0);
      sys_rst = ($urandom_range(0, 199) == 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
